// File: rtl/tdm_serializer_pkg.sv
// Shared types and defaults for the TDM word-to-bit serializer.
package tdm_pkg;

    // Default word width: bits per word and number of select positions.
    localparam int TDM_WIDTH = 4;

    // Serializer FSM: IDLE waits for a word, SHIFT walks the select counter.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tdm_state_e;

endpackage

// File: rtl/tdm_serializer_if.sv
// Word-in / bit-out bus of the TDM serializer.
//
// Handshake: a word moves on a rising edge where in_valid && in_ready, a
// bit moves on a rising edge where out_valid && out_ready. A producer holds
// its payload stable while valid is high and the transfer has not happened;
// ready never depends on the valid of the same channel.
interface tdm_serializer_if
    import tdm_pkg::*;
#(
    parameter int WIDTH = TDM_WIDTH
) ();
    localparam int SEL_W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_bit;
    logic [SEL_W-1:0] out_sel;
    logic             out_first;
    logic             out_last;
    logic             busy;

    // Serializer side of the bus.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_bit, out_sel, out_first, out_last, busy
    );

    // Environment side: supplies words and consumes bits.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_bit, out_sel, out_first, out_last, busy
    );
endinterface

// File: rtl/tdm_serializer_bit_mux.sv
// Combinational WIDTH:1 bit select built as a binary tree of 2:1 muxes.
// Level k halves the candidates using sel_i[k-1], so the LSB of the select
// picks between neighbouring bits first. WIDTH must be a power of two.
module tdm_bit_mux #(
    parameter int WIDTH = 4,
    parameter int SEL_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [SEL_W-1:0] sel_i,
    output logic             bit_o
);

    for (genvar k = 0; k <= SEL_W; k++) begin : g_lvl
        logic [(WIDTH >> k)-1:0] v;
        if (k == 0) begin : g_leaf
            // Leaves are the data bits themselves.
            assign v = data_i;
        end else begin : g_node
            for (genvar j = 0; j < (WIDTH >> k); j++) begin : g_sel
                // One 2:1 selection between a pair of the previous level.
                assign v[j] = sel_i[k-1] ? g_lvl[k-1].v[2*j+1] : g_lvl[k-1].v[2*j];
            end
        end
    end

    assign bit_o = g_lvl[SEL_W].v[0];

endmodule

// File: rtl/tdm_serializer.sv
// TDM serializer: takes parallel words on a valid/ready channel and emits
// them one bit per output beat, LSB first, together with the select index
// that steers a downstream WIDTH:1 mux. A one-entry pending buffer lets the
// next word start on the beat after the previous word's last bit.
// WIDTH must be a power of two and at least 2.
module tdm_serializer
    import tdm_pkg::*;
#(
    parameter int WIDTH = TDM_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    tdm_serializer_if.slave      bus,
    output tdm_state_e           state_o
);

    localparam int SEL_W = $clog2(WIDTH);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(WIDTH - 1);

    tdm_state_e       state_q, state_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_v_q, pend_v_d;

    logic accept;
    logic xfer;
    logic at_last;
    logic last_xfer;
    logic mux_bit;

    // Handshake qualifiers; in_ready depends on registers only.
    assign bus.in_ready = !pend_v_q;
    assign accept       = bus.in_valid && !pend_v_q;
    assign xfer         = (state_q == SHIFT) && bus.out_ready;
    assign at_last      = (sel_q == SEL_LAST);
    assign last_xfer    = xfer && at_last;

    // State, counter and buffers; reset discards any word in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            active_q <= '0;
            sel_q    <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            sel_q    <= sel_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
        end
    end

    // Next-state: load, step, reload from pending or same-edge accept, or stop.
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        sel_d    = sel_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    active_d = bus.in_data;
                    sel_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (xfer && !at_last) begin
                    sel_d = sel_q + SEL_W'(1);
                end else if (last_xfer) begin
                    sel_d = '0;
                    if (pend_v_q) begin
                        active_d = pend_q;
                        pend_v_d = 1'b0;
                    end else if (accept) begin
                        active_d = bus.in_data;
                    end else begin
                        state_d = IDLE;
                    end
                end
                // A word arriving while the active one still has bits to go
                // parks in the pending slot. On a last-bit edge the accept
                // (only possible with the slot empty) went straight to active.
                if (accept && !last_xfer) begin
                    pend_d   = bus.in_data;
                    pend_v_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Serial bit comes from the registered word through the select tree.
    tdm_bit_mux #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_bit_mux (
        .data_i (active_q),
        .sel_i  (sel_q),
        .bit_o  (mux_bit)
    );

    assign bus.out_valid = (state_q == SHIFT);
    assign bus.out_bit   = mux_bit;
    assign bus.out_sel   = sel_q;
    assign bus.out_first = (state_q == SHIFT) && (sel_q == '0);
    assign bus.out_last  = (state_q == SHIFT) && at_last;
    assign bus.busy      = (state_q == SHIFT) || pend_v_q;
    assign state_o       = state_q;

    // Ready must be high whenever the pending slot is free.
    a_ready_when_free : assert property (@(posedge clk) disable iff (rst)
        !pend_v_q |-> bus.in_ready);

    // The select index never leaves the mux range.
    a_sel_in_range : assert property (@(posedge clk) disable iff (rst)
        bus.out_sel <= SEL_LAST);

endmodule

// File: tb/tb_tdm_serializer.sv
// Self-checking bench for tdm_serializer: directed scenarios plus random
// traffic, checked each cycle against a word-queue reference model.
module tb_tdm_serializer;
    import tdm_pkg::*;

    localparam int W     = 4;
    localparam int SW    = $clog2(W);
    localparam int OBS_W = 7 + SW;

    logic       clk;
    logic       rst;
    tdm_state_e state_o;

    tdm_serializer_if #(.WIDTH(W)) bus ();

    tdm_serializer #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state_o)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: words held by the block (head is being sent) and
    // the index of the next bit of the head word.
    logic [W-1:0] exp_q[$];
    int           pos;
    logic         last_acc;
    logic [W-1:0] acc_q[$];
    logic         obs_q[$];

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- model ----------------
    function automatic logic [OBS_W-1:0] model_vec();
        logic [W-1:0]  head;
        logic          v;
        logic          b;
        logic [SW-1:0] s;
        v    = (exp_q.size() > 0);
        head = v ? exp_q[0] : '0;
        b    = v ? head[pos] : 1'b0;
        s    = v ? SW'(pos) : '0;
        return {(exp_q.size() < 2), v, b, s, v && (pos == 0), v && (pos == W - 1), v, v};
    endfunction

    function automatic logic [OBS_W-1:0] dut_vec();
        return {bus.in_ready, bus.out_valid, bus.out_valid & bus.out_bit, bus.out_sel,
                bus.out_first, bus.out_last, bus.busy, (state_o == SHIFT)};
    endfunction

    task automatic model_edge(input logic v, input logic [W-1:0] d, input logic r);
        logic acc;
        acc = v && (exp_q.size() < 2);
        if (exp_q.size() > 0 && r) begin
            pos++;
            if (pos == W) begin
                pos = 0;
                void'(exp_q.pop_front());
            end
        end
        if (acc) begin
            exp_q.push_back(d);
            acc_q.push_back(d);
        end
        last_acc = acc;
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge; leaves the bench at the next falling edge.
    task automatic step(input logic v, input logic [W-1:0] d, input logic r);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        if (bus.out_valid && r) obs_q.push_back(bus.out_bit);
        @(posedge clk);
        model_edge(v, d, r);
        @(negedge clk);
    endtask

    task automatic clear_logs();
        obs_q.delete();
        acc_q.delete();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        exp_q.delete();
        pos = 0;
        repeat (2) @(negedge clk);
        total++;
        if (dut_vec() !== {1'b1, {(OBS_W-1){1'b0}}} || bus.out_bit !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %b bit=%b, required %b bit=0",
                     dut_vec(), bus.out_bit, {1'b1, {(OBS_W-1){1'b0}}});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [W-1:0] got;
        clear_logs();
        step(1'b1, 4'b1011, 1'b1);
        for (int c = 0; c < 6; c++) begin
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL single cyc%0d: got %b, required %b", c, dut_vec(), model_vec());
            end
            step(1'b0, '0, 1'b1);
        end
        got = '0;
        for (int i = 0; i < obs_q.size() && i < W; i++) got[i] = obs_q[i];
        total++;
        if (obs_q.size() != 4 || got !== 4'b1011) begin
            bad++;
            $display("FAIL single_stream: got %b (n=%0d), required 1011 (n=4)", got, obs_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got;
        logic       saw_low;
        clear_logs();
        saw_low = 1'b0;
        step(1'b1, 4'hA, 1'b1);
        for (int c = 0; c < 10; c++) begin
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL b2b cyc%0d: got %b, required %b", c, dut_vec(), model_vec());
            end
            if (!bus.in_ready) saw_low = 1'b1;
            step(c == 0, 4'h5, 1'b1);
        end
        got = '0;
        for (int i = 0; i < obs_q.size() && i < 8; i++) got[i] = obs_q[i];
        total++;
        if (obs_q.size() != 8 || got !== 8'h5A || !saw_low) begin
            bad++;
            $display("FAIL b2b_stream: got %b (n=%0d ready_low=%0b), required 01011010 (n=8 ready_low=1)",
                     got, obs_q.size(), saw_low);
        end
    endtask

    task automatic test_stall();
        logic r;
        clear_logs();
        step(1'b1, 4'hC, 1'b1);
        for (int c = 0; c < 8; c++) begin
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL stall cyc%0d: got %b, required %b", c, dut_vec(), model_vec());
            end
            if (c >= 3 && c <= 5) begin
                total++;
                if (bus.out_sel !== 2'd2 || bus.out_bit !== 1'b1 || !bus.out_valid) begin
                    bad++;
                    $display("FAIL stall_hold cyc%0d: sel=%0d bit=%b valid=%b, required sel=2 bit=1 valid=1",
                             c, bus.out_sel, bus.out_bit, bus.out_valid);
                end
            end
            if (c == 6) begin
                total++;
                if (bus.out_sel !== 2'd3 || bus.out_bit !== 1'b1) begin
                    bad++;
                    $display("FAIL stall_resume: sel=%0d bit=%b, required sel=3 bit=1",
                             bus.out_sel, bus.out_bit);
                end
            end
            // Stall while sel sits at 2 (cycles 2..4 drive ready low).
            r = !(c >= 2 && c <= 4);
            step(1'b0, '0, r);
        end
    endtask

    task automatic test_full();
        int           wait_edges;
        logic [11:0]  got;
        clear_logs();
        step(1'b1, 4'h6, 1'b1);
        step(1'b1, 4'h9, 1'b1);
        wait_edges = 0;
        // Offer the third word until it is taken; bounded by 20 edges.
        for (int c = 0; c < 20; c++) begin
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL full cyc%0d: got %b, required %b", c, dut_vec(), model_vec());
            end
            step(1'b1, 4'hE, 1'b1);
            wait_edges++;
            if (last_acc) break;
        end
        total++;
        if (wait_edges != 4) begin
            bad++;
            $display("FAIL full_accept_time: accepted after %0d edges, required 4", wait_edges);
        end
        for (int c = 0; c < 10; c++) begin
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL full_drain cyc%0d: got %b, required %b", c, dut_vec(), model_vec());
            end
            step(1'b0, '0, 1'b1);
        end
        got = '0;
        for (int i = 0; i < obs_q.size() && i < 12; i++) got[i] = obs_q[i];
        total++;
        if (obs_q.size() != 12 || got !== 12'hE96) begin
            bad++;
            $display("FAIL full_stream: got %h (n=%0d), required e96 (n=12)", got, obs_q.size());
        end
    endtask

    task automatic test_coincide();
        clear_logs();
        step(1'b1, 4'h3, 1'b1);
        for (int c = 0; c < 4; c++) begin
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL coincide cyc%0d: got %b, required %b", c, dut_vec(), model_vec());
            end
            // At c==3 the last bit of 4'h3 is showing; offer 4'h9 now.
            step(c == 3, 4'h9, 1'b1);
        end
        total++;
        if (!bus.out_valid || bus.out_sel !== 2'd0 || bus.out_bit !== 1'b1 || state_o !== SHIFT) begin
            bad++;
            $display("FAIL coincide_no_bubble: valid=%b sel=%0d bit=%b, required valid=1 sel=0 bit=1",
                     bus.out_valid, bus.out_sel, bus.out_bit);
        end
        repeat (5) step(1'b0, '0, 1'b1);
        total++;
        if (dut_vec() !== model_vec()) begin
            bad++;
            $display("FAIL coincide_end: got %b, required %b", dut_vec(), model_vec());
        end
    endtask

    task automatic test_random();
        logic         hold_v;
        logic [W-1:0] hold_d;
        logic         r;
        logic         ok;
        int           n;
        logic [W-1:0] wd;
        clear_logs();
        hold_v = 1'b0;
        hold_d = '0;
        for (int c = 0; c < 400; c++) begin
            if (!hold_v && $urandom_range(0, 2) != 0) begin
                hold_v = 1'b1;
                hold_d = W'($urandom);
            end
            r = ($urandom_range(0, 3) != 0);
            step(hold_v, hold_d, r);
            if (last_acc) hold_v = 1'b0;
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL random cyc%0d: got %b, required %b", c, dut_vec(), model_vec());
            end
        end
        repeat (3 * W) step(1'b0, '0, 1'b1);
        ok = (obs_q.size() == acc_q.size() * W) && (exp_q.size() == 0);
        n  = 0;
        foreach (acc_q[k]) begin
            wd = acc_q[k];
            for (int b = 0; b < W; b++) begin
                if (ok && obs_q[n] !== wd[b]) ok = 1'b0;
                n++;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL random_stream: got %0d bits, required %0d bits of accepted words in order",
                     obs_q.size(), acc_q.size() * W);
        end
    endtask

    task automatic test_mid_reset();
        logic [W-1:0] got;
        clear_logs();
        step(1'b1, 4'hF, 1'b1);
        step(1'b0, '0, 1'b1);
        total++;
        if (bus.out_sel !== 2'd1 || !bus.out_valid) begin
            bad++;
            $display("FAIL midrst_setup: sel=%0d valid=%b, required sel=1 valid=1",
                     bus.out_sel, bus.out_valid);
        end
        rst = 1'b1;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_bit !== 1'b0) begin
            bad++;
            $display("FAIL midrst_immediate: valid=%b busy=%b ready=%b bit=%b, required 0 0 1 0",
                     bus.out_valid, bus.busy, bus.in_ready, bus.out_bit);
        end
        exp_q.delete();
        pos = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || dut_vec() !== model_vec()) begin
            bad++;
            $display("FAIL midrst_release: got %b, required %b", dut_vec(), model_vec());
        end
        clear_logs();
        step(1'b1, 4'h1, 1'b1);
        repeat (5) step(1'b0, '0, 1'b1);
        got = '0;
        for (int i = 0; i < obs_q.size() && i < W; i++) got[i] = obs_q[i];
        total++;
        if (obs_q.size() != 4 || got !== 4'b0001) begin
            bad++;
            $display("FAIL midrst_next_word: got %b (n=%0d), required 0001 (n=4)", got, obs_q.size());
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        pos      = 0;
        last_acc = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_full();
        test_coincide();
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tdm_serializer.md
Name: tdm_serializer

Overview:
- Word-to-bit time-division serializer that feeds a 4:1 select stage.
- Accepts parallel words on a valid/ready input and holds the active word on a registered bus.
- Steps a select counter 0..WIDTH-1 and emits one bit per accepted output beat, LSB first.
- A one-entry pending register allows back-to-back words with no idle beat between them.

Parameters:
- WIDTH, 4, bits per word and number of select positions; must be a power of two and at least 2.
- SEL_W, $clog2(WIDTH), width of the select counter; derived, do not override.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream word valid
- in_ready  output  1  block can accept a word
- in_data  input  WIDTH  parallel word; bit 0 is sent first
- out_valid  output  1  out_bit is valid
- out_ready  input  1  downstream accepts the current bit
- out_bit  output  1  current serial bit, equal to active[out_sel]
- out_sel  output  SEL_W  current select index; this is the sel bus for the downstream mux
- out_first  output  1  high when out_sel == 0 and out_valid
- out_last  output  1  high when out_sel == WIDTH-1 and out_valid
- busy  output  1  high when an active word or a pending word is present

Behaviour:
- Registers:
  - active[WIDTH-1:0] holds the word being sent.
  - sel[SEL_W-1:0] is the select counter.
  - pend[WIDTH-1:0] with pend_v is the one-entry pending buffer.
  - state is IDLE or SHIFT.
- Reset (asynchronous, active-high, takes effect immediately): state=IDLE, active=0, sel=0, pend=0, pend_v=0.
- Outputs during reset: out_valid=0, out_bit=0, out_sel=0, out_first=0, out_last=0, busy=0, in_ready=1.
- in_ready = !pend_v. It is combinational from registers only and never depends on in_valid or out_ready.
- Input accept: in_valid && in_ready at a rising edge. Output transfer: out_valid && out_ready at a rising edge.
- out_valid = (state == SHIFT).
- out_bit and out_sel come straight from registers through the select mux; there is no combinational path from in_* to out_*.
- IDLE state:
  - On accept: active <= in_data, sel <= 0, state <= SHIFT.
  - Latency: out_valid rises one cycle after the accepting edge, with out_bit = in_data[0].
- SHIFT state, transfer with sel != WIDTH-1: sel <= sel + 1.
- SHIFT state, transfer with sel == WIDTH-1 (last bit):
  - If pend_v: active <= pend, pend_v <= 0, sel <= 0, stay in SHIFT. There is no bubble.
  - Else if an accept happens on the same edge: active <= in_data, sel <= 0, stay in SHIFT.
  - Else: state <= IDLE, sel <= 0.
- SHIFT state, accept without a last-bit transfer: pend <= in_data, pend_v <= 1.
- Simultaneous last-bit transfer and accept while pend_v=1 cannot occur, because in_ready=0.
- Stall: while out_valid && !out_ready, out_bit, out_sel, out_first, out_last and active must hold stable. Downstream sees no glitches between edges.
- sel wraps from WIDTH-1 to 0 only on a last-bit transfer and never increments past WIDTH-1.
- Throughput: 1 bit per cycle with out_ready held high, i.e. one word per WIDTH cycles sustained.
- Reset asserted mid-word: the current word and any pending word are discarded and no partial bits are emitted afterwards. After release the block is IDLE with in_ready=1.
- Assertions:
  - in_ready must never be 0 while pend_v is 0.
  - out_sel < WIDTH at all times.

Decomposition:
- Package tdm_pkg holds:
  - the state enum typedef tdm_state_e {IDLE, SHIFT};
  - a localparam default TDM_WIDTH=4.
- Sub-module tdm_bit_mux: purely combinational, parameterized WIDTH, inputs data[WIDTH-1:0] and sel[SEL_W-1:0], output bit.
  - Built as a binary tree of 2:1 selections.
  - Instantiated once to drive out_bit from active and sel.
- The top level contains the FSM, the counter, the pending buffer and the handshake logic.

Test Plan:
- Reset then a single word: in_data=4'b1011 accepted at cycle 1, out_ready=1.
  - Required: out_bit sequence 1,1,0,1 on cycles 2-5, with out_sel 0,1,2,3.
  - Required: out_first at cycle 2, out_last at cycle 5, out_valid=0 at cycle 6.
- Back-to-back words: 4'hA then 4'h5 presented while out_ready=1.
  - Required: 8 contiguous valid bits 0,1,0,1,1,0,1,0 with no gap.
  - Required: in_ready drops while pend_v=1.
- Output stall: out_ready=0 for 3 cycles while at sel=2 of word 4'hC.
  - Required: out_bit=1 and out_sel=2 hold for all 3 cycles, then the sequence resumes at sel=3.
- Full buffer: a third word presented while both active and pend are occupied.
  - Required: in_ready=0 and the third word is not accepted until the last bit of the first word transfers.
- Last-bit transfer coinciding with an accept while pend empty: word 4'h3 at its last bit, 4'h9 accepted on the same edge.
  - Required: the next cycle shows out_sel=0 and out_bit=1 with no IDLE cycle.
- Mid-word reset: assert rst at sel=1 of 4'hF.
  - Required: out_valid=0 immediately.
  - Required: after release in_ready=1 and busy=0, and a new word 4'h1 serializes as 1,0,0,0.
